jtag_uart_master: RTL and testbench
===================================

JTAG_UART_MASTER -- requirements
Module: jtag_uart_master

Interface
REQ-001 SHALL have parameter POLL_GAP, default 16: idle cycles between successive RX polls when no TX byte is pending (1..255).
REQ-002 SHALL have port clock_clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port master_chipselect  output  1  Avalon-MM chipselect to JTAG UART slave.
REQ-005 SHALL have port master_address  output  1  0 = DATA register, 1 = CONTROL register.
REQ-006 SHALL have port master_read_n  output  1  active-low read strobe.
REQ-007 SHALL have port master_write_n  output  1  active-low write strobe.
REQ-008 SHALL have port master_writedata  output  32  write data; [7:0] = character, [31:8] = 0.
REQ-009 SHALL have port master_readdata  input  32  read data from slave.
REQ-010 SHALL have port master_waitrequest  input  1  slave stall.
REQ-011 SHALL have ports tx_data  input  8, tx_valid  input  1, tx_ready  output  1: byte stream to host.
REQ-012 SHALL have ports rx_data  output  8, rx_valid  output  1, rx_ready  input  1: byte stream from host.

Function
REQ-013 SHALL use FSM states IDLE, CTRL_RD, DATA_WR, DATA_RD, GAP.
REQ-014 SHALL hold address, strobes and writedata stable while master_waitrequest=1; transfer completes in the first cycle with chipselect=1 and waitrequest=0, with readdata sampled in that cycle.
REQ-015 SHALL assert at most one of read_n=0/write_n=0, and only with chipselect=1; outside a transfer chipselect=0, read_n=1, write_n=1.
REQ-016 SHALL keep a 16-bit wspace_cnt; IDLE with tx_valid=1: if wspace_cnt=0 -> CTRL_RD (address 1), else -> DATA_WR.
REQ-017 On CTRL_RD completion SHALL load wspace_cnt <= readdata[31:16]; if nonzero -> DATA_WR, else -> DATA_RD (service RX while waiting).
REQ-018 DATA_WR SHALL write tx_data to address 0; tx_ready SHALL pulse 1 cycle in the completion cycle, consuming the byte; wspace_cnt SHALL decrement by 1 (saturating at 0); next state IDLE.
REQ-019 DATA_RD SHALL be entered only when the RX buffer has a free slot; on completion, if readdata[15] (RVALID)=1, readdata[7:0] SHALL be pushed to the RX buffer; if 0, nothing is pushed.
REQ-020 After DATA_RD: if tx_valid=1 -> IDLE; else -> GAP, counting POLL_GAP cycles then -> IDLE; tx_valid=1 SHALL abort GAP to IDLE next cycle.
REQ-021 IDLE with tx_valid=0 and RX slot free -> DATA_RD; IDLE SHALL alternate priority TX/RX after each completed transfer when both are eligible.
REQ-022 rx_valid=1 whenever RX buffer non-empty; pop when rx_valid & rx_ready; simultaneous push and pop in one cycle SHALL both take effect.
REQ-023 SHALL never issue DATA_RD when the RX buffer is full (no character loss).

Reset
REQ-024 On reset_reset=1 at a clock edge: state IDLE, chipselect=0, read_n=1, write_n=1, writedata=0, address=0, tx_ready=0, rx_valid=0, RX buffer empty, wspace_cnt=0, gap counter=0.
REQ-025 Reset mid-transfer SHALL abandon the transfer immediately; a partially written byte is not acknowledged on tx_ready.

Configuration
REQ-026 With JTAG_UART_MASTER_RXFIFO_EN defined, the RX buffer SHALL be a 4-entry FIFO (full at 4); without it, a single holding register (full at 1), with identical port behaviour otherwise.

Verification
REQ-027 tx_valid=1, tx_data=8'h41, CTRL readdata=32'h0040_0000 -> one CTRL read, one write of 32'h0000_0041 to address 0, tx_ready pulse, wspace_cnt=63.
REQ-028 CTRL readdata WSPACE=0 -> no DATA write; DATA_RD issued; CTRL re-read after GAP until WSPACE=1, then byte written.
REQ-029 DATA read returns 32'h0001_8055 -> rx_data=8'h55, rx_valid=1; returns 32'h0000_0000 -> nothing pushed, GAP of POLL_GAP cycles before next poll.
REQ-030 waitrequest held high 5 cycles during write -> outputs stable all 5 cycles; tx_ready only after waitrequest drops.
REQ-031 rx_ready=0, host sends 6 chars -> exactly 4 (FIFO) or 1 (no FIFO) reads issued; polling stops until rx_ready=1.
REQ-032 reset_reset=1 during asserted waitrequest write -> next cycle all outputs at reset values, no tx_ready pulse.

Source files
------------

// File: rtl/jtag_uart_master.sv
// Avalon-MM master that bridges a TX/RX byte-stream pair onto a JTAG UART slave.
// Define JTAG_UART_MASTER_RXFIFO_EN for a 4-entry RX FIFO; otherwise a single holding register is used.
module jtag_uart_master #(
    parameter int POLL_GAP = 16
) (
    input  logic        clock_clk,
    input  logic        reset_reset,
    output logic        master_chipselect,
    output logic        master_address,
    output logic        master_read_n,
    output logic        master_write_n,
    output logic [31:0] master_writedata,
    input  logic [31:0] master_readdata,
    input  logic        master_waitrequest,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready
);
    typedef enum logic [2:0] {IDLE, CTRL_RD, DATA_WR, DATA_RD, GAP} state_t;

    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

    state_t      state;
    logic [15:0] wspace_cnt;
    logic [7:0]  gap_cnt;
    logic        prio_rx;
    logic        done;
    logic        rx_free;
    logic        rx_push;
    logic        rx_pop;
    logic        unused_rd_bits;

    assign done     = master_chipselect & ~master_waitrequest;
    // A write caught by reset in its final cycle is never acknowledged.
    assign tx_ready = (state == DATA_WR) & done & ~reset_reset;
    assign rx_push  = (state == DATA_RD) & done & master_readdata[15] & ~reset_reset;
    assign rx_pop   = rx_valid & rx_ready;
    assign unused_rd_bits = &{1'b0, master_readdata[14:8]};

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            state             <= IDLE;
            master_chipselect <= 1'b0;
            master_address    <= 1'b0;
            master_read_n     <= 1'b1;
            master_write_n    <= 1'b1;
            master_writedata  <= 32'h0;
            wspace_cnt        <= 16'h0;
            gap_cnt           <= 8'h0;
            prio_rx           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_valid && !(prio_rx && rx_free)) begin
                        master_chipselect <= 1'b1;
                        if (wspace_cnt == 16'h0) begin
                            state          <= CTRL_RD;
                            master_address <= 1'b1;
                            master_read_n  <= 1'b0;
                        end else begin
                            state            <= DATA_WR;
                            master_address   <= 1'b0;
                            master_write_n   <= 1'b0;
                            master_writedata <= {24'h0, tx_data};
                        end
                    end else if (rx_free) begin
                        state             <= DATA_RD;
                        master_chipselect <= 1'b1;
                        master_address    <= 1'b0;
                        master_read_n     <= 1'b0;
                    end
                end
                CTRL_RD: begin
                    if (!master_waitrequest) begin
                        wspace_cnt <= master_readdata[31:16];
                        prio_rx    <= 1'b1;
                        if (master_readdata[31:16] != 16'h0) begin
                            state            <= DATA_WR;
                            master_address   <= 1'b0;
                            master_read_n    <= 1'b1;
                            master_write_n   <= 1'b0;
                            master_writedata <= {24'h0, tx_data};
                        end else if (rx_free) begin
                            // No room in the host FIFO: poll RX while waiting for space.
                            state          <= DATA_RD;
                            master_address <= 1'b0;
                        end else begin
                            state             <= GAP;
                            gap_cnt           <= 8'h0;
                            master_chipselect <= 1'b0;
                            master_address    <= 1'b0;
                            master_read_n     <= 1'b1;
                        end
                    end
                end
                DATA_WR: begin
                    if (!master_waitrequest) begin
                        state             <= IDLE;
                        master_chipselect <= 1'b0;
                        master_write_n    <= 1'b1;
                        prio_rx           <= 1'b1;
                        if (wspace_cnt != 16'h0) wspace_cnt <= wspace_cnt - 16'h1;
                    end
                end
                DATA_RD: begin
                    if (!master_waitrequest) begin
                        master_chipselect <= 1'b0;
                        master_read_n     <= 1'b1;
                        prio_rx           <= 1'b0;
                        gap_cnt           <= 8'h0;
                        state             <= tx_valid ? IDLE : GAP;
                    end
                end
                GAP: begin
                    if (tx_valid || gap_cnt == GAP_LAST) state <= IDLE;
                    else gap_cnt <= gap_cnt + 8'h1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef JTAG_UART_MASTER_RXFIFO_EN
    logic [7:0] rx_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] rx_cnt;

    assign rx_free  = (rx_cnt != 3'd4);
    assign rx_valid = (rx_cnt != 3'd0);
    assign rx_data  = rx_mem[rd_ptr];

    always_ff @(posedge clock_clk) begin
        if (rx_push) rx_mem[wr_ptr] <= master_readdata[7:0];
    end

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            rx_cnt <= 3'd0;
        end else begin
            if (rx_push) wr_ptr <= wr_ptr + 2'd1;
            if (rx_pop)  rd_ptr <= rd_ptr + 2'd1;
            rx_cnt <= rx_cnt + {2'b0, rx_push} - {2'b0, rx_pop};
        end
    end
`else
    logic [7:0] rx_hold;
    logic       rx_full;

    assign rx_free  = ~rx_full;
    assign rx_valid = rx_full;
    assign rx_data  = rx_hold;

    always_ff @(posedge clock_clk) begin
        if (rx_push) rx_hold <= master_readdata[7:0];
    end

    always_ff @(posedge clock_clk) begin
        if (reset_reset)  rx_full <= 1'b0;
        else if (rx_push) rx_full <= 1'b1;
        else if (rx_pop)  rx_full <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_jtag_uart_master.sv
// Directed bench for jtag_uart_master with a small Avalon JTAG UART slave model.
module tb_jtag_uart_master;
    localparam int POLL_GAP = 4;
`ifdef JTAG_UART_MASTER_RXFIFO_EN
    localparam int RX_DEPTH = 4;
`else
    localparam int RX_DEPTH = 1;
`endif

    logic        clk;
    logic        rst;
    logic        master_chipselect;
    logic        master_address;
    logic        master_read_n;
    logic        master_write_n;
    logic [31:0] master_writedata;
    logic [31:0] master_readdata;
    logic        master_waitrequest;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    jtag_uart_master #(.POLL_GAP(POLL_GAP)) dut (
        .clock_clk         (clk),
        .reset_reset       (rst),
        .master_chipselect (master_chipselect),
        .master_address    (master_address),
        .master_read_n     (master_read_n),
        .master_write_n    (master_write_n),
        .master_writedata  (master_writedata),
        .master_readdata   (master_readdata),
        .master_waitrequest(master_waitrequest),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model state
    logic [31:0] ctrl_word;
    logic [7:0]  host_chars [16];
    int          host_idx, host_n;
    int          stall, wcnt;
    int          cyc, ctrl_reads, data_reads, valid_reads, writes, tx_acks;
    int          ack_wait, rd_cyc_prev, rd_cyc_last, proto_err, stab_err;
    logic [31:0] last_wdata;
    logic        prev_stall;
    logic [35:0] prev_vec;
    logic [31:0] data_word;
    logic        done;

    assign master_waitrequest = master_chipselect && (wcnt < stall);
    assign done               = master_chipselect && !master_waitrequest;
    assign data_word          = (host_idx < host_n) ? {16'h0001, 8'h80, host_chars[host_idx[3:0]]} : 32'h0;
    assign master_readdata    = master_address ? ctrl_word : data_word;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            wcnt       <= 0;
            prev_stall <= 1'b0;
        end else begin
            wcnt <= (master_chipselect && master_waitrequest) ? wcnt + 1 : 0;
            if (done && !master_read_n && !master_address) begin
                data_reads  <= data_reads + 1;
                rd_cyc_prev <= rd_cyc_last;
                rd_cyc_last <= cyc;
                if (host_idx < host_n) begin
                    host_idx    <= host_idx + 1;
                    valid_reads <= valid_reads + 1;
                end
            end
            if (done && !master_read_n && master_address) ctrl_reads <= ctrl_reads + 1;
            if (done && !master_write_n) begin
                writes     <= writes + 1;
                last_wdata <= master_writedata;
                ack_wait   <= wcnt;
            end
            if (tx_ready) tx_acks <= tx_acks + 1;
            if ((!master_read_n && !master_write_n) ||
                ((!master_read_n || !master_write_n) && !master_chipselect) ||
                (master_chipselect && master_read_n && master_write_n))
                proto_err <= proto_err + 1;
            if (prev_stall && {master_chipselect, master_address, master_read_n, master_write_n, master_writedata} != prev_vec)
                stab_err <= stab_err + 1;
            prev_stall <= master_chipselect && master_waitrequest;
            prev_vec   <= {master_chipselect, master_address, master_read_n, master_write_n, master_writedata};
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    initial begin
        int base_c, base_d, base_w, base_a, base_v, k, ngot;
        logic [7:0] got [6];
        cyc = 0; ctrl_reads = 0; data_reads = 0; valid_reads = 0; writes = 0; tx_acks = 0;
        ack_wait = 0; rd_cyc_prev = 0; rd_cyc_last = 0; proto_err = 0; stab_err = 0;
        last_wdata = 0; host_idx = 0; host_n = 0; stall = 0; ctrl_word = 0;
        prev_vec = 0;
        for (int i = 0; i < 16; i++) host_chars[i] = 8'h0;
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h0; rx_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cs", {31'h0, master_chipselect}, 32'h0);
        check("rst_strobes", {30'h0, master_read_n, master_write_n}, 32'h3);
        check("rst_addr", {31'h0, master_address}, 32'h0);
        check("rst_wdata", master_writedata, 32'h0);
        check("rst_txrdy_rxvld", {30'h0, tx_ready, rx_valid}, 32'h0);
        check("rst_wspace", {16'h0, dut.wspace_cnt}, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single TX byte with 64 free slots reported.
        base_c = ctrl_reads; base_w = writes;
        ctrl_word = 32'h0040_0000; tx_data = 8'h41; tx_valid = 1'b1;
        k = 0;
        while (tx_acks < 1 && k < 60) begin @(negedge clk); k++; end
        tx_valid = 1'b0;
        check("tx1_ack", 32'(tx_acks), 32'd1);
        check("tx1_ctrl_reads", 32'(ctrl_reads - base_c), 32'd1);
        check("tx1_writes", 32'(writes - base_w), 32'd1);
        check("tx1_wdata", last_wdata, 32'h0000_0041);
        check("tx1_wspace", {16'h0, dut.wspace_cnt}, 32'd63);

        // Write held off by waitrequest for 5 cycles.
        stall = 5; base_c = ctrl_reads; tx_data = 8'h42; tx_valid = 1'b1;
        k = 0;
        while (tx_acks < 2 && k < 80) begin @(negedge clk); k++; end
        tx_valid = 1'b0; stall = 0;
        check("stall_ack", 32'(tx_acks), 32'd2);
        check("stall_wait_cycles", 32'(ack_wait), 32'd5);
        check("stall_wdata", last_wdata, 32'h0000_0042);
        check("stall_no_ctrl", 32'(ctrl_reads - base_c), 32'd0);
        check("stall_wspace", {16'h0, dut.wspace_cnt}, 32'd62);

        // One host character, then empty polls spaced by the gap.
        host_chars[host_n[3:0]] = 8'h55; host_n = host_n + 1;
        k = 0;
        while (!rx_valid && k < 40) begin @(negedge clk); k++; end
        check("rx1_valid", {31'h0, rx_valid}, 32'h1);
        check("rx1_data", {24'h0, rx_data}, 32'h55);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("rx1_popped", {31'h0, rx_valid}, 32'h0);
        base_d = data_reads; base_v = valid_reads;
        k = 0;
        while (data_reads < base_d + 2 && k < 60) begin @(negedge clk); k++; end
        check("gap_polls", 32'(data_reads - base_d), 32'd2);
        check("gap_interval", 32'(rd_cyc_last - rd_cyc_prev), 32'(POLL_GAP + 2));
        check("gap_nothing_pushed", {31'h0, rx_valid}, 32'h0);
        check("gap_no_valid_reads", 32'(valid_reads - base_v), 32'd0);

        // Six host characters with the consumer stalled.
        @(negedge clk);
        base_d = data_reads;
        for (int i = 0; i < 6; i++) host_chars[(host_n + i) % 16] = 8'h61 + 8'(i);
        host_n = host_n + 6;
        repeat (100) @(negedge clk);
        check("full_reads", 32'(data_reads - base_d), 32'(RX_DEPTH));
        check("full_head", {24'h0, rx_data}, 32'h61);
        rx_ready = 1'b1;
        ngot = 0; k = 0;
        while (ngot < 6 && k < 300) begin
            if (rx_valid) begin got[ngot] = rx_data; ngot++; end
            @(negedge clk); k++;
        end
        check("drain_count", 32'(ngot), 32'd6);
        for (int i = 0; i < 6; i++) check("drain_data", {24'h0, got[i]}, 32'h61 + 32'(i));

        // No write space: keep polling control, no data write until space appears.
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        base_c = ctrl_reads; base_d = data_reads; base_w = writes; base_a = tx_acks;
        ctrl_word = 32'h0000_0000; tx_data = 8'h43; tx_valid = 1'b1;
        repeat (40) @(negedge clk);
        check("nospace_no_write", 32'(writes - base_w), 32'd0);
        check("nospace_ctrl_repolled", 32'(ctrl_reads - base_c >= 2), 32'd1);
        check("nospace_rx_serviced", 32'(data_reads - base_d >= 1), 32'd1);
        ctrl_word = 32'h0001_0000;
        k = 0;
        while (tx_acks < base_a + 1 && k < 40) begin @(negedge clk); k++; end
        tx_valid = 1'b0;
        check("space_ack", 32'(tx_acks - base_a), 32'd1);
        check("space_wdata", last_wdata, 32'h0000_0043);
        check("space_wspace", {16'h0, dut.wspace_cnt}, 32'd0);

        // Reset during a stalled write.
        stall = 20; ctrl_word = 32'h0010_0000; tx_data = 8'h44; tx_valid = 1'b1;
        base_a = tx_acks;
        k = 0;
        while (!(master_chipselect && !master_write_n && wcnt >= 2) && k < 100) begin @(negedge clk); k++; end
        check("midrst_in_write", {31'h0, master_write_n}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs", {31'h0, master_chipselect}, 32'h0);
        check("midrst_strobes", {30'h0, master_read_n, master_write_n}, 32'h3);
        check("midrst_addr_wdata", {master_address, master_writedata[30:0]}, 32'h0);
        check("midrst_no_ack", 32'(tx_acks - base_a), 32'd0);
        rst = 1'b0; tx_valid = 1'b0; stall = 0;
        repeat (5) @(negedge clk);

        check("protocol_errors", 32'(proto_err), 32'd0);
        check("stall_stability_errors", 32'(stab_err), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
